// File: rtl/prot_relay_sequencer.sv
// rtl/prot_relay_sequencer.sv - input protection relay sequencer with serialized re-enable
// Per-channel fault/hold-off FSM, round-robin re-enable arbiter and a shared coil settle timer.
module prot_relay_sequencer #(
  parameter int NUM_CH        = 4,
  parameter int RETRY_TICKS   = 1024,
  parameter int SETTLE_CYCLES = 64,
  parameter int MAX_RETRIES   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] input_ok,
  input  logic [NUM_CH-1:0] lockout_clear,
  output logic [NUM_CH-1:0] relay_en,
  output logic [NUM_CH-1:0] locked,
  output logic              busy
);

  localparam int CW = (RETRY_TICKS > 1) ? $clog2(RETRY_TICKS) : 1;
  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int FW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CW-1:0] CNT_RELOAD  = CW'(RETRY_TICKS - 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);
  localparam logic [FW-1:0] FAULT_LIMIT = FW'(MAX_RETRIES);
  localparam logic [FW-1:0] FAULT_SAT   = '1;

  typedef enum logic [1:0] {
    ST_OFF_WAIT = 2'd0,
    ST_READY    = 2'd1,
    ST_ON       = 2'd2,
    ST_LOCKED   = 2'd3
  } ch_state_t;

  ch_state_t         state_q [NUM_CH];
  ch_state_t         state_d [NUM_CH];
  logic [CW-1:0]     cnt_q   [NUM_CH];
  logic [CW-1:0]     cnt_d   [NUM_CH];
  logic [FW-1:0]     fault_q [NUM_CH];
  logic [FW-1:0]     fault_d [NUM_CH];
  logic [SW-1:0]     settle_q, settle_d;
  logic [PW-1:0]     rr_q, rr_d;

  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] grant;
  logic [PW-1:0]     arb_idx;
  logic              arb_found;
  logic              fault_any;
  logic [FW-1:0]     fault_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_OFF_WAIT;
        cnt_q[i]   <= CNT_RELOAD;
        fault_q[i] <= '0;
      end
      settle_q <= '0;
      rr_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        fault_q[i] <= fault_d[i];
      end
      settle_q <= settle_d;
      rr_q     <= rr_d;
    end
  end

  always_comb begin
    eligible  = '0;
    grant     = '0;
    arb_idx   = '0;
    arb_found = 1'b0;
    rr_d      = rr_q;
    fault_any = 1'b0;
    fault_inc = '0;

    for (int i = 0; i < NUM_CH; i++) begin
      eligible[i] = (state_q[i] == ST_READY) && input_ok[i] && (settle_q == '0);
    end

    // Search upward from rr_ptr; the first eligible channel takes the single grant.
    for (int k = 0; k < NUM_CH; k++) begin
      arb_idx = PW'((int'(rr_q) + k) % NUM_CH);
      if (!arb_found && eligible[arb_idx]) begin
        arb_found      = 1'b1;
        grant[arb_idx] = 1'b1;
        rr_d           = PW'((int'(arb_idx) + 1) % NUM_CH);
      end
    end

    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      fault_d[i] = fault_q[i];
      fault_inc  = (fault_q[i] == FAULT_SAT) ? FAULT_SAT : fault_q[i] + FW'(1);
      unique case (state_q[i])
        ST_OFF_WAIT: begin
          if (!input_ok[i]) begin
            cnt_d[i] = CNT_RELOAD;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = ST_READY;
          end else begin
            cnt_d[i] = cnt_q[i] - CW'(1);
          end
        end
        ST_READY: begin
          if (!input_ok[i]) begin
            state_d[i] = ST_OFF_WAIT;
            cnt_d[i]   = CNT_RELOAD;
          end else if (grant[i]) begin
            state_d[i] = ST_ON;
            cnt_d[i]   = CNT_RELOAD;
          end
        end
        ST_ON: begin
          if (!input_ok[i]) begin
            fault_any  = 1'b1;
            fault_d[i] = fault_inc;
            cnt_d[i]   = CNT_RELOAD;
            state_d[i] = ((MAX_RETRIES > 0) && (fault_inc == FAULT_LIMIT)) ? ST_LOCKED : ST_OFF_WAIT;
          end else begin
            if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CW'(1);
            // A full hold-off period of clean ON time forgives earlier faults.
            if (cnt_q[i] <= CW'(1)) fault_d[i] = '0;
          end
        end
        ST_LOCKED: begin
          if (lockout_clear[i]) begin
            state_d[i] = ST_OFF_WAIT;
            cnt_d[i]   = CNT_RELOAD;
            fault_d[i] = '0;
          end
        end
        default: state_d[i] = ST_OFF_WAIT;
      endcase
    end

    if (arb_found || fault_any) begin
      settle_d = SETTLE_LOAD;
    end else if (settle_q != '0) begin
      settle_d = settle_q - SW'(1);
    end else begin
      settle_d = '0;
    end
  end

  always_comb begin
    relay_en = '0;
    locked   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      relay_en[i] = (state_q[i] == ST_ON);
      locked[i]   = (state_q[i] == ST_LOCKED);
    end
    busy = (settle_q != '0);
  end

endmodule
